// File: rtl/rv_ctrl_pkg.sv
// Shared encodings for the RV32I multi-cycle controller: opcodes, immediate
// formats, datapath mux selects, FSM states and decoded instruction classes.
package rv_ctrl_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  // EBREAK is the only SYSTEM encoding this core accepts
  localparam logic [31:0] INSTR_EBREAK = 32'h0010_0073;

  localparam logic [2:0] IMM_NONE = 3'd0;
  localparam logic [2:0] IMM_I    = 3'd1;
  localparam logic [2:0] IMM_S    = 3'd2;
  localparam logic [2:0] IMM_B    = 3'd3;
  localparam logic [2:0] IMM_U    = 3'd4;
  localparam logic [2:0] IMM_J    = 3'd5;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;

  localparam logic PC_PLUS4 = 1'b0;
  localparam logic PC_ALU   = 1'b1;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_MEM,
    ST_WB,
    ST_HALT,
    ST_TRAP
  } state_t;

  typedef enum logic [3:0] {
    CLS_LUI,
    CLS_AUIPC,
    CLS_JAL,
    CLS_JALR,
    CLS_BRANCH,
    CLS_LOAD,
    CLS_STORE,
    CLS_OP_IMM,
    CLS_OP,
    CLS_EBREAK,
    CLS_ILLEGAL
  } instr_class_t;

endpackage

// File: rtl/opcode_decode.sv
// Combinational opcode decoder: classifies the held IR contents, flags
// unsupported encodings and picks the immediate format for imm_gen.
module opcode_decode
  import rv_ctrl_pkg::*;
(
  input  logic [31:0]  instr,
  output instr_class_t instr_class,
  output logic         legal,
  output logic [2:0]   imm_sel
);

  always_comb begin
    instr_class = CLS_ILLEGAL;
    imm_sel     = IMM_NONE;
    case (instr[6:0])
      OPC_LUI:    begin instr_class = CLS_LUI;    imm_sel = IMM_U; end
      OPC_AUIPC:  begin instr_class = CLS_AUIPC;  imm_sel = IMM_U; end
      OPC_JAL:    begin instr_class = CLS_JAL;    imm_sel = IMM_J; end
      OPC_JALR:   begin instr_class = CLS_JALR;   imm_sel = IMM_I; end
      OPC_BRANCH: begin instr_class = CLS_BRANCH; imm_sel = IMM_B; end
      OPC_LOAD:   begin instr_class = CLS_LOAD;   imm_sel = IMM_I; end
      OPC_STORE:  begin instr_class = CLS_STORE;  imm_sel = IMM_S; end
      OPC_OP_IMM: begin instr_class = CLS_OP_IMM; imm_sel = IMM_I; end
      OPC_OP:     begin instr_class = CLS_OP;     imm_sel = IMM_NONE; end
      OPC_SYSTEM: begin
        if (instr == INSTR_EBREAK) instr_class = CLS_EBREAK;
      end
      default: ;
    endcase
    legal = (instr_class != CLS_ILLEGAL);
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I control FSM: sequences fetch/decode/execute/memory/writeback
// over a shared single-port memory and counts retired instructions.
module multicycle_ctrl
  import rv_ctrl_pkg::*;
#(
  parameter int INSTRET_W = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 run,
  input  logic [31:0]          instr,
  input  logic                 mem_ready,
  input  logic                 branch_taken,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic                 ir_we,
  output logic                 pc_we,
  output logic                 pc_sel,
  output logic [2:0]           imm_sel,
  output logic                 alu_a_sel,
  output logic                 alu_b_sel,
  output logic                 rf_we,
  output logic [1:0]           wb_sel,
  output logic                 halted,
  output logic                 illegal,
  output logic [INSTRET_W-1:0] instret
);

  state_t       state, state_next;
  instr_class_t instr_class;
  logic         legal;
  logic [2:0]   dec_imm_sel;
  logic         retire, set_halted, set_illegal;
  logic         mem_req_raw, ir_we_raw, pc_we_raw, rf_we_raw;

  opcode_decode u_decode (
    .instr       (instr),
    .instr_class (instr_class),
    .legal       (legal),
    .imm_sel     (dec_imm_sel)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_FETCH;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instret <= '0;
      halted  <= 1'b0;
      illegal <= 1'b0;
    end else begin
      if (retire)      instret <= instret + INSTRET_W'(1);
      if (set_halted)  halted  <= 1'b1;
      if (set_illegal) illegal <= 1'b1;
    end
  end

  always_comb begin
    state_next  = state;
    mem_req_raw = 1'b0;
    mem_we      = 1'b0;
    ir_we_raw   = 1'b0;
    pc_we_raw   = 1'b0;
    pc_sel      = PC_PLUS4;
    imm_sel     = IMM_NONE;
    alu_a_sel   = 1'b0;
    alu_b_sel   = 1'b0;
    rf_we_raw   = 1'b0;
    wb_sel      = WB_ALU;
    retire      = 1'b0;
    set_halted  = 1'b0;
    set_illegal = 1'b0;
    case (state)
      ST_FETCH: begin
        mem_req_raw = run;
        if (run && mem_ready) begin
          ir_we_raw  = 1'b1;
          pc_we_raw  = 1'b1;
          state_next = ST_DECODE;
        end
      end
      ST_DECODE: begin
        imm_sel = dec_imm_sel;
        if (!legal) begin
          set_illegal = 1'b1;
          state_next  = ST_TRAP;
        end else if (instr_class == CLS_EBREAK) begin
          set_halted = 1'b1;
          retire     = 1'b1;
          state_next = ST_HALT;
        end else begin
          state_next = ST_EXEC;
        end
      end
      ST_EXEC: begin
        imm_sel   = dec_imm_sel;
        alu_a_sel = instr_class inside {CLS_AUIPC, CLS_JAL, CLS_BRANCH};
        alu_b_sel = (instr_class != CLS_OP);
        case (instr_class)
          CLS_BRANCH: begin
            if (branch_taken) begin
              pc_we_raw = 1'b1;
              pc_sel    = PC_ALU;
            end
            retire     = 1'b1;
            state_next = ST_FETCH;
          end
          CLS_LOAD, CLS_STORE: state_next = ST_MEM;
          default:             state_next = ST_WB;
        endcase
      end
      ST_MEM: begin
        imm_sel     = dec_imm_sel;
        mem_req_raw = 1'b1;
        mem_we      = (instr_class == CLS_STORE);
        if (mem_ready) begin
          if (instr_class == CLS_STORE) begin
            retire     = 1'b1;
            state_next = ST_FETCH;
          end else begin
            state_next = ST_WB;
          end
        end
      end
      ST_WB: begin
        imm_sel   = dec_imm_sel;
        rf_we_raw = 1'b1;
        if (instr_class == CLS_LOAD) begin
          wb_sel = WB_MEM;
        end else if (instr_class inside {CLS_JAL, CLS_JALR}) begin
          wb_sel    = WB_PC4;
          pc_we_raw = 1'b1;
          pc_sel    = PC_ALU;
        end
        retire     = 1'b1;
        state_next = ST_FETCH;
      end
      ST_HALT, ST_TRAP: ;
      default: state_next = ST_FETCH;
    endcase
  end

  // Strobes that would corrupt memory or architectural state are held off during reset
  assign mem_req = rst_n & mem_req_raw;
  assign ir_we   = rst_n & ir_we_raw;
  assign pc_we   = rst_n & pc_we_raw;
  assign rf_we   = rst_n & rf_we_raw;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: each scenario queues per-cycle stimulus
// with the expected outputs and instret, then replays and compares it.
module tb_multicycle_ctrl;

  logic        clk, rst_n, run, mem_ready, branch_taken;
  logic [31:0] instr;
  logic        mem_req, mem_we, ir_we, pc_we, pc_sel, alu_a_sel, alu_b_sel, rf_we, halted, illegal;
  logic [2:0]  imm_sel;
  logic [1:0]  wb_sel;
  logic [31:0] instret;
  logic [14:0] obs;

  int          tests_run = 0;
  int          failures  = 0;
  logic [31:0] model_instret = 0;

  typedef struct {
    string       tag;
    logic        run_i;
    logic        rdy_i;
    logic        bt_i;
    logic [14:0] outv;
    logic [31:0] ret;
  } sb_item_t;

  sb_item_t sb_q[$];

  multicycle_ctrl #(.INSTRET_W(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .run          (run),
    .instr        (instr),
    .mem_ready    (mem_ready),
    .branch_taken (branch_taken),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .ir_we        (ir_we),
    .pc_we        (pc_we),
    .pc_sel       (pc_sel),
    .imm_sel      (imm_sel),
    .alu_a_sel    (alu_a_sel),
    .alu_b_sel    (alu_b_sel),
    .rf_we        (rf_we),
    .wb_sel       (wb_sel),
    .halted       (halted),
    .illegal      (illegal),
    .instret      (instret)
  );

  assign obs = {mem_req, mem_we, ir_we, pc_we, pc_sel, imm_sel,
                alu_a_sel, alu_b_sel, rf_we, wb_sel, halted, illegal};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [14:0] ov(input logic req, we, irw, pcw, psel,
                                     input logic [2:0] imm,
                                     input logic a, b, rf,
                                     input logic [1:0] wb,
                                     input logic h, il);
    return {req, we, irw, pcw, psel, imm, a, b, rf, wb, h, il};
  endfunction

  function automatic void push(input string tag, input logic r, rdy, bt, input logic [14:0] v);
    sb_item_t it;
    it.tag   = tag;
    it.run_i = r;
    it.rdy_i = rdy;
    it.bt_i  = bt;
    it.outv  = v;
    it.ret   = model_instret;
    sb_q.push_back(it);
  endfunction

  function automatic void retire();
    model_instret = model_instret + 1;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    run = 1'b0;
    rst_n = 1'b0;
    model_instret = 0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1; run = 1'b1; mem_ready = 1'b1; branch_taken = 1'b0;
    instr = 32'h0050_0093;
    #1 rst_n = 1'b0;
    #1;
    tests_run++;
    if ({mem_req, ir_we, pc_we, rf_we} !== 4'b0000) begin
      failures++;
      $display("[TB] FAIL reset_strobes got %b expected 0000", {mem_req, ir_we, pc_we, rf_we});
    end
    tests_run++;
    if ({halted, illegal, imm_sel} !== 5'b0) begin
      failures++;
      $display("[TB] FAIL reset_flags got %b expected 00000", {halted, illegal, imm_sel});
    end
    tests_run++;
    if (instret !== 32'd0) begin
      failures++;
      $display("[TB] FAIL reset_instret got %0d expected 0", instret);
    end
    @(negedge clk);
    run = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_alu();
    sb_item_t it;
    instr = 32'h0050_0093;
    push("addi_fetch",  1, 1, 0, ov(1,0,1,1,0, 3'd0, 0,0,0, 2'd0, 0,0));
    push("addi_decode", 0, 1, 0, ov(0,0,0,0,0, 3'd1, 0,0,0, 2'd0, 0,0));
    push("addi_exec",   0, 1, 0, ov(0,0,0,0,0, 3'd1, 0,1,0, 2'd0, 0,0));
    push("addi_wb",     0, 1, 0, ov(0,0,0,0,0, 3'd1, 0,0,1, 2'd0, 0,0));
    retire();
    push("addi_idle0",  0, 1, 0, ov(0,0,0,0,0, 3'd0, 0,0,0, 2'd0, 0,0));
    push("addi_idle1",  0, 1, 0, ov(0,0,0,0,0, 3'd0, 0,0,0, 2'd0, 0,0));
    while (sb_q.size() > 0) begin
      it = sb_q.pop_front();
      @(negedge clk);
      run = it.run_i; mem_ready = it.rdy_i; branch_taken = it.bt_i;
      #1;
      tests_run++;
      if (obs !== it.outv) begin
        failures++;
        $display("[TB] FAIL %s outputs got %b expected %b", it.tag, obs, it.outv);
      end
      tests_run++;
      if (instret !== it.ret) begin
        failures++;
        $display("[TB] FAIL %s instret got %0d expected %0d", it.tag, instret, it.ret);
      end
    end
  endtask

  task automatic test_store();
    sb_item_t it;
    instr = 32'h0020_a223;
    push("sw_fetch",  1, 1, 0, ov(1,0,1,1,0, 3'd0, 0,0,0, 2'd0, 0,0));
    push("sw_decode", 0, 0, 0, ov(0,0,0,0,0, 3'd2, 0,0,0, 2'd0, 0,0));
    push("sw_exec",   0, 0, 0, ov(0,0,0,0,0, 3'd2, 0,1,0, 2'd0, 0,0));
    push("sw_mem0",   0, 0, 0, ov(1,1,0,0,0, 3'd2, 0,0,0, 2'd0, 0,0));
    push("sw_mem1",   0, 0, 0, ov(1,1,0,0,0, 3'd2, 0,0,0, 2'd0, 0,0));
    push("sw_mem2",   0, 1, 0, ov(1,1,0,0,0, 3'd2, 0,0,0, 2'd0, 0,0));
    retire();
    push("sw_idle",   0, 1, 0, ov(0,0,0,0,0, 3'd0, 0,0,0, 2'd0, 0,0));
    while (sb_q.size() > 0) begin
      it = sb_q.pop_front();
      @(negedge clk);
      run = it.run_i; mem_ready = it.rdy_i; branch_taken = it.bt_i;
      #1;
      tests_run++;
      if (obs !== it.outv) begin
        failures++;
        $display("[TB] FAIL %s outputs got %b expected %b", it.tag, obs, it.outv);
      end
      tests_run++;
      if (instret !== it.ret) begin
        failures++;
        $display("[TB] FAIL %s instret got %0d expected %0d", it.tag, instret, it.ret);
      end
    end
  endtask

  task automatic test_load();
    sb_item_t it;
    instr = 32'h0000_a103;
    push("lw_fetchwait", 1, 0, 0, ov(1,0,0,0,0, 3'd0, 0,0,0, 2'd0, 0,0));
    push("lw_fetch",     1, 1, 0, ov(1,0,1,1,0, 3'd0, 0,0,0, 2'd0, 0,0));
    push("lw_decode",    0, 1, 0, ov(0,0,0,0,0, 3'd1, 0,0,0, 2'd0, 0,0));
    push("lw_exec",      0, 1, 0, ov(0,0,0,0,0, 3'd1, 0,1,0, 2'd0, 0,0));
    push("lw_mem0",      0, 0, 0, ov(1,0,0,0,0, 3'd1, 0,0,0, 2'd0, 0,0));
    push("lw_mem1",      0, 1, 0, ov(1,0,0,0,0, 3'd1, 0,0,0, 2'd0, 0,0));
    push("lw_wb",        0, 1, 0, ov(0,0,0,0,0, 3'd1, 0,0,1, 2'd1, 0,0));
    retire();
    push("lw_idle",      0, 1, 0, ov(0,0,0,0,0, 3'd0, 0,0,0, 2'd0, 0,0));
    while (sb_q.size() > 0) begin
      it = sb_q.pop_front();
      @(negedge clk);
      run = it.run_i; mem_ready = it.rdy_i; branch_taken = it.bt_i;
      #1;
      tests_run++;
      if (obs !== it.outv) begin
        failures++;
        $display("[TB] FAIL %s outputs got %b expected %b", it.tag, obs, it.outv);
      end
      tests_run++;
      if (instret !== it.ret) begin
        failures++;
        $display("[TB] FAIL %s instret got %0d expected %0d", it.tag, instret, it.ret);
      end
    end
  endtask

  task automatic test_branch();
    sb_item_t it;
    instr = 32'h0020_8463;
    push("beq_t_fetch",  1, 1, 0, ov(1,0,1,1,0, 3'd0, 0,0,0, 2'd0, 0,0));
    push("beq_t_decode", 0, 1, 1, ov(0,0,0,0,0, 3'd3, 0,0,0, 2'd0, 0,0));
    push("beq_t_exec",   0, 1, 1, ov(0,0,0,1,1, 3'd3, 1,1,0, 2'd0, 0,0));
    retire();
    push("beq_n_fetch",  1, 1, 0, ov(1,0,1,1,0, 3'd0, 0,0,0, 2'd0, 0,0));
    push("beq_n_decode", 0, 0, 0, ov(0,0,0,0,0, 3'd3, 0,0,0, 2'd0, 0,0));
    push("beq_n_exec",   0, 0, 0, ov(0,0,0,0,0, 3'd3, 1,1,0, 2'd0, 0,0));
    retire();
    push("beq_idle",     0, 1, 1, ov(0,0,0,0,0, 3'd0, 0,0,0, 2'd0, 0,0));
    while (sb_q.size() > 0) begin
      it = sb_q.pop_front();
      @(negedge clk);
      run = it.run_i; mem_ready = it.rdy_i; branch_taken = it.bt_i;
      #1;
      tests_run++;
      if (obs !== it.outv) begin
        failures++;
        $display("[TB] FAIL %s outputs got %b expected %b", it.tag, obs, it.outv);
      end
      tests_run++;
      if (instret !== it.ret) begin
        failures++;
        $display("[TB] FAIL %s instret got %0d expected %0d", it.tag, instret, it.ret);
      end
    end
  endtask

  task automatic test_jal();
    sb_item_t it;
    instr = 32'h0080_00ef;
    push("jal_fetch",  1, 1, 0, ov(1,0,1,1,0, 3'd0, 0,0,0, 2'd0, 0,0));
    push("jal_decode", 1, 1, 0, ov(0,0,0,0,0, 3'd5, 0,0,0, 2'd0, 0,0));
    push("jal_exec",   1, 1, 0, ov(0,0,0,0,0, 3'd5, 1,1,0, 2'd0, 0,0));
    push("jal_wb",     1, 1, 0, ov(0,0,0,1,1, 3'd5, 0,0,1, 2'd2, 0,0));
    retire();
    push("jal_idle",   0, 1, 0, ov(0,0,0,0,0, 3'd0, 0,0,0, 2'd0, 0,0));
    while (sb_q.size() > 0) begin
      it = sb_q.pop_front();
      @(negedge clk);
      run = it.run_i; mem_ready = it.rdy_i; branch_taken = it.bt_i;
      #1;
      tests_run++;
      if (obs !== it.outv) begin
        failures++;
        $display("[TB] FAIL %s outputs got %b expected %b", it.tag, obs, it.outv);
      end
      tests_run++;
      if (instret !== it.ret) begin
        failures++;
        $display("[TB] FAIL %s instret got %0d expected %0d", it.tag, instret, it.ret);
      end
    end
  endtask

  task automatic test_illegal_halt();
    sb_item_t it;
    instr = 32'h0000_0000;
    push("ill_fetch",  1, 1, 0, ov(1,0,1,1,0, 3'd0, 0,0,0, 2'd0, 0,0));
    push("ill_decode", 1, 1, 0, ov(0,0,0,0,0, 3'd0, 0,0,0, 2'd0, 0,0));
    push("ill_trap0",  1, 1, 0, ov(0,0,0,0,0, 3'd0, 0,0,0, 2'd0, 0,1));
    push("ill_trap1",  1, 1, 1, ov(0,0,0,0,0, 3'd0, 0,0,0, 2'd0, 0,1));
    while (sb_q.size() > 0) begin
      it = sb_q.pop_front();
      @(negedge clk);
      run = it.run_i; mem_ready = it.rdy_i; branch_taken = it.bt_i;
      #1;
      tests_run++;
      if (obs !== it.outv) begin
        failures++;
        $display("[TB] FAIL %s outputs got %b expected %b", it.tag, obs, it.outv);
      end
      tests_run++;
      if (instret !== it.ret) begin
        failures++;
        $display("[TB] FAIL %s instret got %0d expected %0d", it.tag, instret, it.ret);
      end
    end
    do_reset();
    instr = 32'h0010_0073;
    push("ebreak_fetch",  1, 1, 0, ov(1,0,1,1,0, 3'd0, 0,0,0, 2'd0, 0,0));
    push("ebreak_decode", 1, 1, 0, ov(0,0,0,0,0, 3'd0, 0,0,0, 2'd0, 0,0));
    retire();
    push("ebreak_halt0",  1, 1, 0, ov(0,0,0,0,0, 3'd0, 0,0,0, 2'd0, 1,0));
    push("ebreak_halt1",  1, 1, 1, ov(0,0,0,0,0, 3'd0, 0,0,0, 2'd0, 1,0));
    while (sb_q.size() > 0) begin
      it = sb_q.pop_front();
      @(negedge clk);
      run = it.run_i; mem_ready = it.rdy_i; branch_taken = it.bt_i;
      #1;
      tests_run++;
      if (obs !== it.outv) begin
        failures++;
        $display("[TB] FAIL %s outputs got %b expected %b", it.tag, obs, it.outv);
      end
      tests_run++;
      if (instret !== it.ret) begin
        failures++;
        $display("[TB] FAIL %s instret got %0d expected %0d", it.tag, instret, it.ret);
      end
    end
  endtask

  task automatic test_reset_mid_mem();
    sb_item_t it;
    do_reset();
    instr = 32'h0050_0093;
    push("rm_addi_fetch",  1, 1, 0, ov(1,0,1,1,0, 3'd0, 0,0,0, 2'd0, 0,0));
    push("rm_addi_decode", 0, 1, 0, ov(0,0,0,0,0, 3'd1, 0,0,0, 2'd0, 0,0));
    push("rm_addi_exec",   0, 1, 0, ov(0,0,0,0,0, 3'd1, 0,1,0, 2'd0, 0,0));
    push("rm_addi_wb",     0, 1, 0, ov(0,0,0,0,0, 3'd1, 0,0,1, 2'd0, 0,0));
    retire();
    while (sb_q.size() > 0) begin
      it = sb_q.pop_front();
      @(negedge clk);
      run = it.run_i; mem_ready = it.rdy_i; branch_taken = it.bt_i;
      #1;
      tests_run++;
      if (obs !== it.outv) begin
        failures++;
        $display("[TB] FAIL %s outputs got %b expected %b", it.tag, obs, it.outv);
      end
      tests_run++;
      if (instret !== it.ret) begin
        failures++;
        $display("[TB] FAIL %s instret got %0d expected %0d", it.tag, instret, it.ret);
      end
    end
    instr = 32'h0000_a103;
    push("rm_lw_fetch",  1, 1, 0, ov(1,0,1,1,0, 3'd0, 0,0,0, 2'd0, 0,0));
    push("rm_lw_decode", 1, 0, 0, ov(0,0,0,0,0, 3'd1, 0,0,0, 2'd0, 0,0));
    push("rm_lw_exec",   1, 0, 0, ov(0,0,0,0,0, 3'd1, 0,1,0, 2'd0, 0,0));
    push("rm_lw_mem",    1, 0, 0, ov(1,0,0,0,0, 3'd1, 0,0,0, 2'd0, 0,0));
    while (sb_q.size() > 0) begin
      it = sb_q.pop_front();
      @(negedge clk);
      run = it.run_i; mem_ready = it.rdy_i; branch_taken = it.bt_i;
      #1;
      tests_run++;
      if (obs !== it.outv) begin
        failures++;
        $display("[TB] FAIL %s outputs got %b expected %b", it.tag, obs, it.outv);
      end
      tests_run++;
      if (instret !== it.ret) begin
        failures++;
        $display("[TB] FAIL %s instret got %0d expected %0d", it.tag, instret, it.ret);
      end
    end
    // Assert reset between clock edges while the load waits in MEM
    #2 rst_n = 1'b0;
    model_instret = 0;
    #1;
    tests_run++;
    if ({mem_req, ir_we, pc_we, rf_we} !== 4'b0000) begin
      failures++;
      $display("[TB] FAIL midmem_strobes got %b expected 0000", {mem_req, ir_we, pc_we, rf_we});
    end
    tests_run++;
    if (instret !== 32'd0) begin
      failures++;
      $display("[TB] FAIL midmem_instret got %0d expected 0", instret);
    end
    @(negedge clk);
    run = 1'b0;
    rst_n = 1'b1;
    push("rm_post_idle0", 0, 1, 0, ov(0,0,0,0,0, 3'd0, 0,0,0, 2'd0, 0,0));
    push("rm_post_idle1", 0, 1, 0, ov(0,0,0,0,0, 3'd0, 0,0,0, 2'd0, 0,0));
    push("rm_post_fetch", 1, 0, 0, ov(1,0,0,0,0, 3'd0, 0,0,0, 2'd0, 0,0));
    while (sb_q.size() > 0) begin
      it = sb_q.pop_front();
      @(negedge clk);
      run = it.run_i; mem_ready = it.rdy_i; branch_taken = it.bt_i;
      #1;
      tests_run++;
      if (obs !== it.outv) begin
        failures++;
        $display("[TB] FAIL %s outputs got %b expected %b", it.tag, obs, it.outv);
      end
      tests_run++;
      if (instret !== it.ret) begin
        failures++;
        $display("[TB] FAIL %s instret got %0d expected %0d", it.tag, instret, it.ret);
      end
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_store();
    test_load();
    test_branch();
    test_jal();
    test_illegal_halt();
    test_reset_mid_mem();
    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multi-cycle control FSM for the RV32I core. It sequences fetch, decode, execute, memory and writeback over the shared single-port memory, register file, ALU and `imm_gen`. It selects the immediate format fed to `imm_gen`, drives all datapath write strobes and mux selects, and counts retired instructions.

## Interface
Parameters:
- `INSTRET_W`, default 32, width of the retired-instruction counter.

Ports:
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `run` in 1: permits a new fetch when high.
- `instr` in 32: current IR contents, held by the datapath.
- `mem_ready` in 1: memory completes the current access this cycle.
- `branch_taken` in 1: ALU branch-compare result, valid in EXEC.
- `mem_req` out 1: memory access request.
- `mem_we` out 1: store when high, read when low.
- `ir_we` out 1: load IR and capture old PC.
- `pc_we` out 1: PC write enable.
- `pc_sel` out 1: PC source, 0 = PC+4, 1 = ALU target.
- `imm_sel` out 3: immediate format for `imm_gen`.
- `alu_a_sel` out 1: ALU A input, 0 = rs1, 1 = old PC.
- `alu_b_sel` out 1: ALU B input, 0 = rs2, 1 = imm.
- `rf_we` out 1: register-file write enable.
- `wb_sel` out 2: writeback source, 0 = ALU, 1 = mem, 2 = old PC+4.
- `halted` out 1: sticky; set on EBREAK.
- `illegal` out 1: sticky; set on an unknown opcode.
- `instret` out INSTRET_W: retired-instruction count.

## Operation
- States: FETCH, DECODE, EXEC, MEM, WB, HALT, TRAP.
- Instruction classes, decoded from `instr[6:0]`: LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111, BRANCH 1100011, LOAD 0000011, STORE 0100011, OP-IMM 0010011, OP 0110011, SYSTEM 1110011.
- Only EBREAK (0x00100073) is legal under SYSTEM. Every other encoding, including 0x00000000, is illegal.
- `imm_sel` encoding:
  - 0 = none
  - 1 = I (OP-IMM, LOAD, JALR)
  - 2 = S
  - 3 = B
  - 4 = U (LUI, AUIPC)
  - 5 = J
- `imm_sel` is valid in DECODE through WB and is 0 in FETCH, HALT and TRAP.
- FETCH: `mem_req`=`run`, `mem_we`=0. When `run`&`mem_ready`: pulse `ir_we`=1, `pc_we`=1 with `pc_sel`=0, then go to DECODE. Otherwise stay in FETCH.
- DECODE: one cycle.
  - Illegal opcode: go to TRAP and set `illegal`.
  - EBREAK: go to HALT, set `halted`, and increment `instret`.
  - Any other class: go to EXEC.
- EXEC: one cycle. `alu_a_sel`=1 for AUIPC, JAL and BRANCH. `alu_b_sel`=1 for every class except OP. Next state:
  - BRANCH: if `branch_taken`, assert `pc_we`=1 with `pc_sel`=1. Retire, then go to FETCH.
  - LOAD or STORE: go to MEM.
  - All other classes: go to WB.
- MEM: `mem_req`=1, `mem_we`=1 for STORE. Wait until `mem_ready`. On completion, STORE retires and goes to FETCH; LOAD goes to WB.
- WB: one cycle with `rf_we`=1, then retire and go to FETCH.
  - `wb_sel` is 1 for LOAD, 2 for JAL and JALR, and 0 otherwise.
  - JAL and JALR also assert `pc_we`=1 with `pc_sel`=1.
- LUI uses rs1 = x0 in the datapath. The FSM sequence for LUI is the same as for OP-IMM.
- HALT and TRAP are absorbing. Only reset exits them. All strobes are 0 in both states.
- Retire means `instret` increments by 1. It wraps modulo 2^INSTRET_W.

## Timing
- Reset (asynchronous, `rst_n` low):
  - state = FETCH; `instret`=0; `halted`=0; `illegal`=0.
  - `mem_req`, `ir_we`, `pc_we` and `rf_we` are forced to 0 while `rst_n` is low.
  - Reset asserted mid-MEM drops `mem_req` immediately. Memory must abandon the access.
- Outputs are combinational from the state register and `instr`. FETCH and MEM strobes also depend on `mem_ready` (Mealy).
- Latency, with zero memory wait:
  - ALU or jump class: 4 cycles.
  - BRANCH: 3 cycles.
  - STORE: 4 cycles.
  - LOAD: 5 cycles.
  - Each memory wait cycle adds 1.
- `run` is sampled only in FETCH. Dropping `run` in any other state does not stall the current instruction.
- `mem_ready` outside FETCH and MEM is ignored.
- `instret` updates on the clock edge that leaves the retiring state.

## Structure
- A shared package `rv_ctrl_pkg` holds:
  - the opcode constants;
  - the `imm_sel` encodings, which `imm_gen` also uses;
  - the `wb_sel` and `pc_sel` encodings;
  - the state enum.
- One sub-module, `opcode_decode`, is combinational. It maps `instr` to a class and a legal flag, and it also supplies `imm_sel`.
- The FSM, the `instret` counter and the sticky flags live in `multicycle_ctrl`.

## Test plan
- `instr`=0x00500093 (addi), `mem_ready`=1 → FETCH, DECODE, EXEC, WB. `imm_sel`=1, `alu_b_sel`=1. One-cycle `rf_we` pulse with `wb_sel`=0. `instret`=1.
- `instr`=0x0020a223 (sw), `mem_ready` low for 2 MEM cycles → `imm_sel`=2. `mem_req`=1 and `mem_we`=1 for 3 MEM cycles. No `rf_we`. Retire after MEM.
- `instr`=0x00208463 (beq): `branch_taken`=1 → `pc_we`=1 and `pc_sel`=1 in EXEC, `imm_sel`=3. `branch_taken`=0 → no `pc_we` in EXEC. Both cases return to FETCH after 3 cycles.
- `instr`=0x008000ef (jal) → `imm_sel`=5, `alu_a_sel`=1 in EXEC. In WB: `rf_we`=1, `wb_sel`=2, `pc_we`=1, `pc_sel`=1.
- `instr`=0x00000000 → TRAP, `illegal`=1, `instret` unchanged, `mem_req` stays 0. `instr`=0x00100073 → HALT, `halted`=1, `instret` increments by 1.
- `rst_n` pulled low mid-MEM of a load → `mem_req`=0 immediately, state = FETCH, `instret`=0. With `run`=0 after release → `mem_req`=0 and the FSM stays in FETCH.
